// File: rtl/led_pio_pkg.sv
// Shared constants and types for the led_pio register block.
package led_pio_pkg;

  localparam logic [2:0] ADDR_DATA         = 3'd0;
  localparam logic [2:0] ADDR_BLINK_MASK   = 3'd2;
  localparam logic [2:0] ADDR_BLINK_PERIOD = 3'd3;
  localparam logic [2:0] ADDR_OUTSET       = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR     = 3'd5;

  typedef logic [7:0] period_t;

  function automatic logic is_write(input logic chipselect, input logic write_n);
    return chipselect & ~write_n;
  endfunction

endpackage

// File: rtl/led_pio_if.sv
// Avalon-MM slave bus of the led_pio block.
interface led_pio_if #(parameter int WIDTH = 8);

  logic             chipselect;
  logic             write_n;
  logic [2:0]       address;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] readdata;

  modport master (output chipselect, write_n, address, writedata, input readdata);
  modport slave  (input chipselect, write_n, address, writedata, output readdata);

endinterface

// File: rtl/led_pio_blink_timer.sv
// Blink timer: free-running prescaler, 8-bit period counter and phase.
// Output phase is the value phase takes at the coming clk edge.
module led_pio_blink_timer
  import led_pio_pkg::*;
#(
  parameter int PRESCALE = 50000
) (
  input  logic    clk,
  input  logic    reset_n,
  input  period_t period,
  input  logic    restart,
  output logic    phase
);

  localparam int PW = $clog2(PRESCALE);

  logic [PW-1:0] pre_q, pre_d;
  period_t       cnt_q, cnt_d;
  logic          phase_q, phase_d, tick;

  assign tick  = (pre_q == PW'(PRESCALE - 1));
  assign phase = phase_d;

  always_comb begin
    pre_d   = tick ? '0 : pre_q + PW'(1);
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (restart) begin
      pre_d   = '0;
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (period == '0) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (tick) begin
      if (cnt_q == period - 8'd1) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/led_pio.sv
// LED parallel output with set/clear registers and optional blinking.
// Blink support is built only when LED_PIO_BLINK_EN is defined.
module led_pio
  import led_pio_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  led_pio_if.slave         bus,
  output logic [WIDTH-1:0] out_port
);

  if (WIDTH < 1 || WIDTH > 32 || PRESCALE < 2) begin : g_bad_param
    $error("led_pio: WIDTH must be 1..32 and PRESCALE >= 2");
  end

  logic             wr;
  logic [WIDTH-1:0] data_q, data_next, rd_mux, pin_next;

  assign wr = is_write(bus.chipselect, bus.write_n);

  always_comb begin
    data_next = data_q;
    if (wr) begin
      case (bus.address)
        ADDR_DATA:     data_next = bus.writedata;
        ADDR_OUTSET:   data_next = data_q | bus.writedata;
        ADDR_OUTCLEAR: data_next = data_q & ~bus.writedata;
        default:       data_next = data_q;
      endcase
    end
  end

`ifdef LED_PIO_BLINK_EN
  logic [WIDTH-1:0] mask_q, mask_next;
  period_t          period_q, period_next;
  logic             restart, phase;

  assign restart     = wr && (bus.address == ADDR_BLINK_PERIOD);
  assign mask_next   = (wr && bus.address == ADDR_BLINK_MASK) ? bus.writedata : mask_q;
  assign period_next = restart ? period_t'(bus.writedata) : period_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q   <= '0;
      period_q <= '0;
    end else begin
      mask_q   <= mask_next;
      period_q <= period_next;
    end
  end

  led_pio_blink_timer #(.PRESCALE(PRESCALE)) u_blink_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (period_q),
    .restart (restart),
    .phase   (phase)
  );

  // Masked bits are forced low during the off phase.
  assign pin_next = data_next & ~(mask_next & {WIDTH{~phase}});
`else
  assign pin_next = data_next;
`endif

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_DATA:         rd_mux = data_q;
`ifdef LED_PIO_BLINK_EN
      ADDR_BLINK_MASK:   rd_mux = mask_q;
      ADDR_BLINK_PERIOD: rd_mux = WIDTH'(period_q);
`else
      ADDR_BLINK_MASK:   rd_mux = '0;
      ADDR_BLINK_PERIOD: rd_mux = '0;
`endif
      default:           rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q       <= '0;
      bus.readdata <= '0;
      out_port     <= '0;
    end else begin
      data_q       <= data_next;
      bus.readdata <= rd_mux;
      out_port     <= pin_next;
    end
  end

endmodule

// File: tb/tb_led_pio.sv
// Directed bench for led_pio with a cycle-level behavioural model.
module tb_led_pio;

  localparam int WIDTH    = 8;
  localparam int PRESCALE = 4;

  logic             clk     = 1'b0;
  logic             reset_n = 1'b1;
  logic             chk_en  = 1'b0;
  logic [WIDTH-1:0] out_port;
  logic [7:0]       v;
  int               vectors     = 0;
  int               miscompares = 0;

  led_pio_if #(.WIDTH(WIDTH)) bus();

  led_pio #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

  // Model: phase depends only on edges elapsed since the last period write.
  logic [7:0] m_data = '0, m_mask = '0, m_per = '0, exp_out = '0, exp_rd = '0;
  int         m_k = 0;

  always @(posedge clk or negedge reset_n) begin : model
    logic [7:0] d, mk, pr, rd;
    int         kk;
    logic       ph;
    if (!reset_n) begin
      m_data  <= '0;
      m_mask  <= '0;
      m_per   <= '0;
      m_k     <= 0;
      exp_out <= '0;
      exp_rd  <= '0;
    end else begin
      d  = m_data;
      mk = m_mask;
      pr = m_per;
      kk = m_k + 1;
      case (bus.address)
        3'd0:    rd = m_data;
        3'd2:    rd = m_mask;
        3'd3:    rd = m_per;
        default: rd = '0;
      endcase
      if (bus.chipselect && !bus.write_n) begin
        case (bus.address)
          3'd0: d = bus.writedata;
          3'd4: d = m_data | bus.writedata;
          3'd5: d = m_data & ~bus.writedata;
`ifdef LED_PIO_BLINK_EN
          3'd2: mk = bus.writedata;
          3'd3: begin pr = bus.writedata; kk = 0; end
`endif
          default: ;
        endcase
      end
      ph = (pr == 8'd0) || (((kk / (PRESCALE * int'(pr))) % 2) == 0);
      m_data  <= d;
      m_mask  <= mk;
      m_per   <= pr;
      m_k     <= kk;
      exp_rd  <= rd;
      exp_out <= d & ~(mk & {8{~ph}});
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_out", out_port, exp_out);
      check("cyc_rd", bus.readdata, exp_rd);
    end
  end

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.address = a;
    @(negedge clk);
    d = bus.readdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 3'd0;
    bus.writedata  = '0;
    #1 reset_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out", out_port, 8'h00);
    check("rst_rd", bus.readdata, 8'h00);
    reset_n = 1'b1;

    wr(3'd0, 8'hA5);
    check("wr_data_pin", out_port, 8'hA5);
    check("model_wr_data", exp_out, 8'hA5);
    rd(3'd0, v);
    check("rd_data", v, 8'hA5);

    wr(3'd0, 8'h0F);
    wr(3'd4, 8'h30);
    check("outset_pin", out_port, 8'h3F);
    check("model_outset", exp_out, 8'h3F);
    wr(3'd5, 8'h03);
    check("outclear_pin", out_port, 8'h3C);
    rd(3'd4, v);
    check("rd_outset", v, 8'h00);
    rd(3'd5, v);
    check("rd_outclear", v, 8'h00);
    rd(3'd1, v);
    check("rd_reserved", v, 8'h00);
    wr(3'd6, 8'hFF);
    check("wr_ignored", out_port, 8'h3C);
    rd(3'd7, v);
    check("rd_addr7", v, 8'h00);

`ifdef LED_PIO_BLINK_EN
    wr(3'd0, 8'hFF);
    wr(3'd2, 8'h01);
    wr(3'd3, 8'h03);
    for (int j = 0; j < 36; j++) begin
      if (j > 0) @(negedge clk);
      check("blink_bit0", {7'b0, out_port[0]}, {7'b0, ((j / 12) % 2) == 0});
      check("blink_hi", {1'b0, out_port[7:1]}, 8'h7F);
    end
    rd(3'd2, v);
    check("rd_mask", v, 8'h01);
    rd(3'd3, v);
    check("rd_period", v, 8'h03);

    wr(3'd3, 8'h00);
    wr(3'd2, 8'hFF);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check("period0_steady", out_port, 8'hFF);
    end
    wr(3'd3, 8'h02);
    repeat (5) @(negedge clk);
    wr(3'd3, 8'h02);
    for (int j = 0; j < 10; j++) begin
      if (j > 0) @(negedge clk);
      check("restart_blink", out_port, (j < 8) ? 8'hFF : 8'h00);
    end
    wr(3'd2, 8'h0F);
    repeat (10) @(negedge clk);

    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("async_rst_out", out_port, 8'h00);
    check("async_rst_rd", bus.readdata, 8'h00);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v);
      check("post_rst_rd", v, 8'h00);
    end
    check("post_rst_out", out_port, 8'h00);
`else
    wr(3'd2, 8'hFF);
    rd(3'd2, v);
    check("nb_rd_mask", v, 8'h00);
    wr(3'd3, 8'h05);
    rd(3'd3, v);
    check("nb_rd_period", v, 8'h00);
    wr(3'd0, 8'hC3);
    check("nb_pin", out_port, 8'hC3);
    check("model_nb_pin", exp_out, 8'hC3);
    repeat (20) @(negedge clk);
    check("nb_pin_steady", out_port, 8'hC3);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
